// File: rtl/hud_pkg.sv
// Shared types and helpers for the HUD health-digit controller.
// Holds the flash FSM state type and the clamp/BCD split used for the digit slots.
package hud_pkg;

    localparam int DIGIT_W = 64;
    localparam int COLOR_W = 12;
    localparam logic [COLOR_W-1:0] TRANSPARENT = 12'h000;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FLASH = 1'b1
    } flash_state_t;

    function automatic logic [6:0] hp_clamp(input logic [6:0] hp, input logic [6:0] hp_max);
        logic [6:0] res;
        if (hp > hp_max) begin
            res = hp_max;
        end else begin
            res = hp;
        end
        return res;
    endfunction

    // Restoring ladder with weights 80/40/20/10 yields the tens digit one bit at a time.
    function automatic logic [7:0] bcd_split(input logic [6:0] hp, input logic [6:0] hp_max);
        logic [6:0] rem;
        logic [3:0] tens;
        rem = hp_clamp(hp, hp_max);
        if (rem >= 7'd80) begin rem = rem - 7'd80; tens[3] = 1'b1; end else begin tens[3] = 1'b0; end
        if (rem >= 7'd40) begin rem = rem - 7'd40; tens[2] = 1'b1; end else begin tens[2] = 1'b0; end
        if (rem >= 7'd20) begin rem = rem - 7'd20; tens[1] = 1'b1; end else begin tens[1] = 1'b0; end
        if (rem >= 7'd10) begin rem = rem - 7'd10; tens[0] = 1'b1; end else begin tens[0] = 1'b0; end
        return {tens, rem[3:0]};
    endfunction

endpackage

// File: rtl/hp_flash_fsm.sv
// Per-player flash sequencer: blinks a player's digits for a fixed number of
// frames after the sampled health drops.
module hp_flash_fsm
    import hud_pkg::*;
#(
    parameter int HP_MAX       = 99,
    parameter int FLASH_FRAMES = 32,
    parameter int BLINK_BIT    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic [6:0] hp,
    input  logic [7:0] frame_cnt,
    output logic       visible
);

    flash_state_t state_r, state_s;
    logic [7:0]   cnt_r, cnt_s;
    logic [6:0]   prev_hp_r, prev_hp_s;
    logic [6:0]   hp_clamped_s;
    logic         drop_s;

    // State, remaining-frames counter and last sampled health
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            cnt_r     <= 8'd0;
            prev_hp_r <= 7'(HP_MAX);
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            prev_hp_r <= prev_hp_s;
        end
    end

    // Next state: health is only looked at on frame_tick; a drop always (re)starts the flash
    always_comb begin
        hp_clamped_s = hp_clamp(hp, 7'(HP_MAX));
        drop_s       = frame_tick && (hp_clamped_s < prev_hp_r);
        state_s      = state_r;
        cnt_s        = cnt_r;
        prev_hp_s    = prev_hp_r;
        if (frame_tick) begin
            prev_hp_s = hp_clamped_s;
            if (drop_s) begin
                state_s = FLASH;
                cnt_s   = 8'(FLASH_FRAMES - 1);
            end else begin
                case (state_r)
                    FLASH: begin
                        if (cnt_r == 8'd0) begin
                            state_s = IDLE;
                        end else begin
                            cnt_s = cnt_r - 8'd1;
                        end
                    end
                    default: begin
                        state_s = IDLE;
                    end
                endcase
            end
        end else begin
            prev_hp_s = prev_hp_r;
        end
    end

    // Visibility: steady in IDLE, gated by the shared frame counter while flashing
    always_comb begin
        case (state_r)
            FLASH:   visible = (((frame_cnt >> BLINK_BIT) & 8'd1) == 8'd0);
            default: visible = 1'b1;
        endcase
    end

endmodule

// File: rtl/hud_blood_ctrl.sv
// HUD health-digit sequencer: decodes the four digit slots, addresses the shared
// digit ROM bank and produces the registered HUD pixel two clocks after x/y.
module hud_blood_ctrl
    import hud_pkg::*;
#(
    parameter int P1_X0        = 16,
    parameter int P2_X0        = 496,
    parameter int HUD_Y0       = 16,
    parameter int HP_MAX       = 99,
    parameter int FLASH_FRAMES = 32,
    parameter int BLINK_BIT    = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               video_on,
    input  logic [9:0]         x,
    input  logic [9:0]         y,
    input  logic               frame_tick,
    input  logic [6:0]         p1_hp,
    input  logic [6:0]         p2_hp,
    output logic [5:0]         rom_row,
    output logic [5:0]         rom_col,
    output logic [3:0]         rom_sel,
    input  logic [COLOR_W-1:0] rom_color,
    output logic               blood_on,
    output logic [COLOR_W-1:0] rgb_out
);

    logic               row_hit_s;
    logic               slot_hit_s;
    logic [1:0]         slot_idx_s;
    logic [9:0]         slot_x0_s;
    logic [7:0]         p1_bcd_s, p2_bcd_s;
    logic [3:0]         digit_s;
    logic               vis_s;
    logic               p1_vis_s, p2_vis_s;
    logic [7:0]         frame_cnt_r;
    logic [3:0]         rom_sel_r;
    logic               hit_d_r, vis_d_r;
    logic               blood_on_r;
    logic [COLOR_W-1:0] rgb_out_r;

    // Slot decode: index 0/1 = P1 tens/ones, 2/3 = P2 tens/ones
    always_comb begin
        row_hit_s  = video_on && (y >= 10'(HUD_Y0)) && (y < 10'(HUD_Y0 + DIGIT_W));
        slot_hit_s = 1'b0;
        slot_idx_s = 2'd0;
        slot_x0_s  = 10'd0;
        if (row_hit_s) begin
            if ((x >= 10'(P1_X0)) && (x < 10'(P1_X0 + DIGIT_W))) begin
                slot_hit_s = 1'b1; slot_idx_s = 2'd0; slot_x0_s = 10'(P1_X0);
            end else if ((x >= 10'(P1_X0 + DIGIT_W)) && (x < 10'(P1_X0 + 2*DIGIT_W))) begin
                slot_hit_s = 1'b1; slot_idx_s = 2'd1; slot_x0_s = 10'(P1_X0 + DIGIT_W);
            end else if ((x >= 10'(P2_X0)) && (x < 10'(P2_X0 + DIGIT_W))) begin
                slot_hit_s = 1'b1; slot_idx_s = 2'd2; slot_x0_s = 10'(P2_X0);
            end else if ((x >= 10'(P2_X0 + DIGIT_W)) && (x < 10'(P2_X0 + 2*DIGIT_W))) begin
                slot_hit_s = 1'b1; slot_idx_s = 2'd3; slot_x0_s = 10'(P2_X0 + DIGIT_W);
            end else begin
                slot_hit_s = 1'b0;
            end
        end else begin
            slot_hit_s = 1'b0;
        end
    end

    // ROM address, forced to zero outside the digit slots
    always_comb begin
        if (slot_hit_s) begin
            rom_row = 6'(y - 10'(HUD_Y0));
            rom_col = 6'(x - slot_x0_s);
        end else begin
            rom_row = 6'd0;
            rom_col = 6'd0;
        end
    end

    assign p1_bcd_s = bcd_split(p1_hp, 7'(HP_MAX));
    assign p2_bcd_s = bcd_split(p2_hp, 7'(HP_MAX));

    // Digit and owner visibility for the addressed slot
    always_comb begin
        case (slot_idx_s)
            2'd0:    digit_s = p1_bcd_s[7:4];
            2'd1:    digit_s = p1_bcd_s[3:0];
            2'd2:    digit_s = p2_bcd_s[7:4];
            2'd3:    digit_s = p2_bcd_s[3:0];
            default: digit_s = 4'd0;
        endcase
        if (slot_idx_s[1]) begin
            vis_s = p2_vis_s;
        end else begin
            vis_s = p1_vis_s;
        end
    end

    // Shared blink phase, advanced once per frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt_r <= 8'd0;
        end else if (frame_tick) begin
            frame_cnt_r <= frame_cnt_r + 8'd1;
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end

    hp_flash_fsm #(
        .HP_MAX       (HP_MAX),
        .FLASH_FRAMES (FLASH_FRAMES),
        .BLINK_BIT    (BLINK_BIT)
    ) u_p1_flash (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .hp         (p1_hp),
        .frame_cnt  (frame_cnt_r),
        .visible    (p1_vis_s)
    );

    hp_flash_fsm #(
        .HP_MAX       (HP_MAX),
        .FLASH_FRAMES (FLASH_FRAMES),
        .BLINK_BIT    (BLINK_BIT)
    ) u_p2_flash (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .hp         (p2_hp),
        .frame_cnt  (frame_cnt_r),
        .visible    (p2_vis_s)
    );

    // Stage 1: digit select lines up with the ROM read data on the next cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rom_sel_r <= 4'd0;
            hit_d_r   <= 1'b0;
            vis_d_r   <= 1'b0;
        end else begin
            rom_sel_r <= slot_hit_s ? digit_s : 4'd0;
            hit_d_r   <= slot_hit_s;
            vis_d_r   <= vis_s;
        end
    end

    // Stage 2: black ROM pixels are transparent
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blood_on_r <= 1'b0;
            rgb_out_r  <= 12'h000;
        end else if (hit_d_r && vis_d_r && (rom_color != TRANSPARENT)) begin
            blood_on_r <= 1'b1;
            rgb_out_r  <= rom_color;
        end else begin
            blood_on_r <= 1'b0;
            rgb_out_r  <= 12'h000;
        end
    end

    assign rom_sel  = rom_sel_r;
    assign blood_on = blood_on_r;
    assign rgb_out  = rgb_out_r;

endmodule

// File: tb/tb_hud_blood_ctrl.sv
// Directed self-checking bench for hud_blood_ctrl: slot decode, digit split,
// pipeline latency, transparency and the per-player flash sequencing.
module tb_hud_blood_ctrl;

    localparam int P1_X0  = 16;
    localparam int P2_X0  = 496;
    localparam int HUD_Y0 = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        video_on;
    logic [9:0]  x, y;
    logic        frame_tick;
    logic [6:0]  p1_hp, p2_hp;
    logic [5:0]  rom_row, rom_col;
    logic [3:0]  rom_sel;
    logic [11:0] rom_color;
    logic        blood_on;
    logic [11:0] rgb_out;

    int errors = 0;
    int checks = 0;
    logic [7:0] fc;

    // boundary table: x, y, expected blood_on
    int bx [11] = '{15, 16, 143, 144, 495, 623, 624, 21, 21, 21, 21};
    int by [11] = '{19, 19, 19,  19,  19,  19,  19,  15, 16, 79, 80};
    int be [11] = '{0,  1,  1,   0,   0,   1,   0,   0,  1,  1,  0};

    hud_blood_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .video_on   (video_on),
        .x          (x),
        .y          (y),
        .frame_tick (frame_tick),
        .p1_hp      (p1_hp),
        .p2_hp      (p2_hp),
        .rom_row    (rom_row),
        .rom_col    (rom_col),
        .rom_sel    (rom_sel),
        .rom_color  (rom_color),
        .blood_on   (blood_on),
        .rgb_out    (rgb_out)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Called at a falling edge: drive a pixel, then check the HUD output two clocks later
    task automatic pix_check(input string tag, input int px, input int py,
                             input logic [11:0] col, input logic exp_on);
        x = 10'(px);
        y = 10'(py);
        rom_color = col;
        @(negedge clk);
        @(negedge clk);
        check_val(tag, {31'd0, blood_on}, {31'd0, exp_on});
        check_val({tag, "_rgb"}, {20'd0, rgb_out}, exp_on ? {20'd0, col} : 32'd0);
    endtask

    // One frame tick, then probe both players' visibility
    task automatic tick_check(input logic f1, input logic f2);
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        fc = fc + 8'd1;
        pix_check("p1_vis", P1_X0 + 5, HUD_Y0 + 3, 12'hABC, f1 ? ~fc[2] : 1'b1);
        pix_check("p2_vis", P2_X0 + 70, HUD_Y0 + 3, 12'hABC, f2 ? ~fc[2] : 1'b1);
    endtask

    initial begin
        reset = 1'b1; video_on = 1'b1; x = 10'd0; y = 10'd0; frame_tick = 1'b0;
        p1_hp = 7'd57; p2_hp = 7'd99; rom_color = 12'h000; fc = 8'd0;
        @(negedge clk);
        @(negedge clk);
        check_val("rst_blood_on", {31'd0, blood_on}, 32'd0);
        check_val("rst_rgb", {20'd0, rgb_out}, 32'd0);
        check_val("rst_rom_sel", {28'd0, rom_sel}, 32'd0);
        reset = 1'b0;

        // latency: in-slot pixel followed by an out-of-slot pixel
        @(negedge clk);
        x = 10'(P1_X0 + 5); y = 10'(HUD_Y0 + 3); rom_color = 12'h5A5;
        #1;
        check_val("row", {26'd0, rom_row}, 32'd3);
        check_val("col", {26'd0, rom_col}, 32'd5);
        @(negedge clk);
        check_val("sel_p1_tens", {28'd0, rom_sel}, 32'd5);
        check_val("lat1_off", {31'd0, blood_on}, 32'd0);
        x = 10'(P1_X0 - 1);
        @(negedge clk);
        check_val("lat2_on", {31'd0, blood_on}, 32'd1);
        check_val("lat2_rgb", {20'd0, rgb_out}, 32'h5A5);
        @(negedge clk);
        check_val("lat3_off", {31'd0, blood_on}, 32'd0);
        check_val("lat3_rgb", {20'd0, rgb_out}, 32'd0);

        // remaining slots: P1 ones, P2 tens, P2 ones
        x = 10'(P1_X0 + 64); #1;
        check_val("col_p1_ones", {26'd0, rom_col}, 32'd0);
        @(negedge clk);
        check_val("sel_p1_ones", {28'd0, rom_sel}, 32'd7);
        x = 10'(P2_X0); #1;
        check_val("col_p2_tens", {26'd0, rom_col}, 32'd0);
        @(negedge clk);
        check_val("sel_p2_tens", {28'd0, rom_sel}, 32'd9);
        x = 10'(P2_X0 + 64); #1;
        check_val("col_p2_ones", {26'd0, rom_col}, 32'd0);
        @(negedge clk);
        check_val("sel_p2_ones", {28'd0, rom_sel}, 32'd9);
        x = 10'(P2_X0 + 127); y = 10'(HUD_Y0 + 63); #1;
        check_val("row_last", {26'd0, rom_row}, 32'd63);
        check_val("col_last", {26'd0, rom_col}, 32'd63);
        @(negedge clk);

        // slot edges in x and y
        for (int i = 0; i < 11; i++) begin
            pix_check("edge", bx[i], by[i], 12'h0F0, be[i][0]);
        end

        // clamp and zero
        p1_hp = 7'd120;
        x = 10'(P1_X0); y = 10'(HUD_Y0); @(negedge clk);
        check_val("clamp_tens", {28'd0, rom_sel}, 32'd9);
        x = 10'(P1_X0 + 64); @(negedge clk);
        check_val("clamp_ones", {28'd0, rom_sel}, 32'd9);
        p1_hp = 7'd0;
        x = 10'(P1_X0); @(negedge clk);
        check_val("zero_tens", {28'd0, rom_sel}, 32'd0);
        x = 10'(P1_X0 + 64); @(negedge clk);
        check_val("zero_ones", {28'd0, rom_sel}, 32'd0);
        p1_hp = 7'd57;

        // transparency and blanking
        pix_check("transparent", P1_X0 + 5, HUD_Y0 + 3, 12'h000, 1'b0);
        video_on = 1'b0;
        pix_check("video_off", P1_X0 + 5, HUD_Y0 + 3, 12'hABC, 1'b0);
        video_on = 1'b1;

        // first tick after reset: both below max, so both flash together
        p2_hp = 7'd80;
        for (int k = 0; k < 34; k++) begin
            tick_check(k <= 31, k <= 31);
        end

        // P2 drop 80->70, re-drop to 60 at tick 10; P1 health rises without effect
        p2_hp = 7'd70;
        for (int k = 0; k < 44; k++) begin
            if (k == 10) p2_hp = 7'd60;
            if (k == 5)  p1_hp = 7'd70;
            tick_check(1'b0, k <= 41);
        end

        // reset in the middle of a P2 flash with a visible P1 pixel on screen
        p2_hp = 7'd50;
        tick_check(1'b0, 1'b1);
        pix_check("pre_reset", P1_X0 + 5, HUD_Y0 + 3, 12'hF00, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check_val("async_blood_on", {31'd0, blood_on}, 32'd0);
        check_val("async_rgb", {20'd0, rgb_out}, 32'd0);
        check_val("async_rom_sel", {28'd0, rom_sel}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        fc = 8'd0;
        p1_hp = 7'd99;
        p2_hp = 7'd99;
        for (int k = 0; k < 4; k++) begin
            tick_check(1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
